// File: rtl/mux_logic_unit_pipe_if.sv
// Operand/result handshake bundle for mux_logic_unit_pipe.
// The slave modport is the block's view; the master modport is the view of the source and consumer.
interface mux_logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_op, in_a, in_b, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_beats
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_y, out_beats
  );
endinterface

// File: rtl/mux_logic_unit_pipe.sv
// Registered WIDTH-bit 2-input logic unit built from per-bit 2:1 muxes, with a valid/ready
// handshake and a multi-beat accumulate mode that feeds each result back as the next A operand.
module mux_logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_logic_unit_pipe_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] mux_d0;
  logic [WIDTH-1:0] mux_d1;
  logic [WIDTH-1:0] f_y;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_ready_int;
  logic             beat_xfer;

  // Inside a sequence the running result replaces in_a as the mux select.
  assign op_a         = (state_q == ACCUM) ? acc_q : bus.in_a;
  assign in_ready_int = !out_valid_q || bus.out_ready;
  assign beat_xfer    = bus.in_valid && in_ready_int;
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    mux_d0 = '0;
    mux_d1 = '0;
    case (bus.in_op)
      3'd0: begin mux_d0 = '1;          mux_d1 = '0;          end
      3'd1: begin mux_d0 = '0;          mux_d1 = bus.in_b;    end
      3'd2: begin mux_d0 = bus.in_b;    mux_d1 = '1;          end
      3'd3: begin mux_d0 = '1;          mux_d1 = ~bus.in_b;   end
      3'd4: begin mux_d0 = ~bus.in_b;   mux_d1 = '0;          end
      3'd5: begin mux_d0 = bus.in_b;    mux_d1 = ~bus.in_b;   end
      3'd6: begin mux_d0 = ~bus.in_b;   mux_d1 = bus.in_b;    end
      default: begin mux_d0 = '0;       mux_d1 = '1;          end
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_mux
      assign f_y[gi] = op_a[gi] ? mux_d1[gi] : mux_d0[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_y_d     = out_y_q;
    out_beats_d = out_beats_q;
    // A drain clears the register unless a producing beat reloads it below.
    out_valid_d = out_valid_q && !bus.out_ready;
    if (beat_xfer) begin
      case (state_q)
        IDLE: begin
          if (bus.in_acc && !bus.in_last) begin
            acc_d   = f_y;
            cnt_d   = CNT_ONE;
            state_d = ACCUM;
          end else begin
            out_y_d     = f_y;
            out_beats_d = CNT_ONE;
            out_valid_d = 1'b1;
          end
        end
        ACCUM: begin
          if (bus.in_last) begin
            out_y_d     = f_y;
            out_beats_d = cnt_inc;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            acc_d = f_y;
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_y_q     <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_y_q     <= out_y_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_beats = out_beats_q;
endmodule

// File: tb/tb_mux_logic_unit_pipe.sv
// Scoreboard bench: two instances (beat counter 4 and 2 bits) share one stimulus stream;
// a reference model pushes expected results and a negedge monitor pops and compares.
module tb_mux_logic_unit_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_logic_unit_pipe_if #(.WIDTH(W), .CNT_W(4)) bus ();
  mux_logic_unit_pipe_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_op     = bus.in_op;
  assign bus2.in_a      = bus.in_a;
  assign bus2.in_b      = bus.in_b;
  assign bus2.in_acc    = bus.in_acc;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  mux_logic_unit_pipe #(.WIDTH(W), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  mux_logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [W-1:0] y;
    int           n;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           fails  = 0;
  bit           m_in_seq = 1'b0;
  logic [W-1:0] m_acc;
  int           m_n;
  bit           rand_run;

  function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic int sat(input int n, input int cw);
    int m;
    m = (1 << cw) - 1;
    return (n > m) ? m : n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor first, then model update: outputs seen now reflect transfers up to the last edge.
  always @(negedge clk) begin
    bit   pend;
    exp_t e;
    pend = (exp_q.size() != 0);
    chk("in_ready", 64'(bus.in_ready), 64'(!pend || bus.out_ready));
    chk("out_valid", 64'(bus.out_valid), 64'(pend));
    chk("sat_out_valid", 64'(bus2.out_valid), 64'(pend));
    if (pend && bus.out_valid) begin
      e = exp_q[0];
      chk("out_y", 64'(bus.out_y), 64'(e.y));
      chk("out_beats", 64'(bus.out_beats), 64'(sat(e.n, 4)));
      chk("sat_out_y", 64'(bus2.out_y), 64'(e.y));
      chk("sat_out_beats", 64'(bus2.out_beats), 64'(sat(e.n, 2)));
      $display("result y=%02h beats=%0d/%0d ready=%0b", bus.out_y, bus.out_beats,
               bus2.out_beats, bus.out_ready);
      if (bus.out_ready) void'(exp_q.pop_front());
    end
    if (rst) begin
      exp_q.delete();
      m_in_seq = 1'b0;
    end else if (bus.in_valid && bus.in_ready) begin
      logic [W-1:0] r;
      if (!m_in_seq) begin
        r = ref_f(bus.in_op, bus.in_a, bus.in_b);
        if (bus.in_acc && !bus.in_last) begin
          m_in_seq = 1'b1;
          m_acc    = r;
          m_n      = 1;
        end else begin
          exp_q.push_back('{y: r, n: 1});
        end
      end else begin
        r   = ref_f(bus.in_op, m_acc, bus.in_b);
        m_n = m_n + 1;
        if (bus.in_last) begin
          exp_q.push_back('{y: r, n: m_n});
          m_in_seq = 1'b0;
        end else begin
          m_acc = r;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic acc, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = acc;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 50 cycles at %0t", $time);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_acc    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rand_run      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_y", 64'(bus.out_y), 64'(0));
    chk("reset_out_beats", 64'(bus.out_beats), 64'(0));
    chk("reset_sat_out_beats", 64'(bus2.out_beats), 64'(0));
    @(posedge clk);
    #1;

    // All eight functions back-to-back on F0/CC.
    for (int op = 0; op < 8; op++) send(3'(op), 8'hF0, 8'hCC, 1'b0, 1'b0);
    idle(2);

    // Three-beat accumulate: (0F^01)&07|80 = 86.
    send(3'd5, 8'h0F, 8'h01, 1'b1, 1'b0);
    send(3'd1, 8'h00, 8'h07, 1'b0, 1'b0);
    send(3'd2, 8'h00, 8'h80, 1'b0, 1'b1);
    idle(2);

    // Backpressure: result held 3 cycles, then drain and reload together.
    bus.out_ready = 1'b0;
    send(3'd1, 8'hFF, 8'h3C, 1'b0, 1'b0);
    fork
      send(3'd6, 8'h55, 8'hAA, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(2);

    // PASS accumulate: 5 beats and 17 beats, both counters saturate somewhere.
    a0 = 8'hA7;
    send(3'd7, a0, 8'h11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(3'd7, W'($urandom), W'($urandom), 1'b0, 1'b0);
    send(3'd7, 8'h00, 8'h00, 1'b0, 1'b1);
    send(3'd7, 8'h3E, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) send(3'd7, W'($urandom), W'($urandom), 1'b1, 1'b0);
    send(3'd7, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Reset mid-sequence, then a single AND beat must not see stale accumulate state.
    send(3'd5, 8'h33, 8'h0F, 1'b1, 1'b0);
    send(3'd2, 8'h00, 8'h40, 1'b0, 1'b0);
    pulse_reset();
    @(negedge clk);
    chk("midseq_reset_out_y", 64'(bus.out_y), 64'(0));
    chk("midseq_reset_out_beats", 64'(bus.out_beats), 64'(0));
    @(posedge clk);
    #1;
    send(3'd1, 8'hFF, 8'h5A, 1'b0, 1'b0);
    idle(2);

    // Reset wins over a simultaneous drain and beat.
    bus.out_ready = 1'b0;
    send(3'd2, 8'h12, 8'h34, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_op     = 3'd5;
    bus.in_a      = 8'hAA;
    bus.in_b      = 8'h0F;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b1;
    pulse_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("reset_collide_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_collide_out_y", 64'(bus.out_y), 64'(0));
    @(posedge clk);
    #1;

    // Random traffic with random consumer backpressure.
    rand_run = 1'b1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          int gap;
          send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
               1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
          gap = $urandom_range(0, 1);
          if (gap != 0) idle(gap);
        end
        send(3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        rand_run = 1'b0;
      end
    join
    bus.out_ready = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mux_logic_unit_pipe.md
Name: mux_logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit mux-built gate set.
- Applies one of eight 2-input bitwise functions to WIDTH-bit operands. Every result bit is built only from 2:1 muxes: select = a bit, data inputs = constant, b or ~b.
- Adds a valid/ready handshake, a 1-cycle output register, and a multi-beat accumulate mode that chains results across beats.
- Sits between an operand source and a downstream consumer in the datapath library.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 4, width of the beat counter (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_op  input  3  function select: 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a.
- in_a  input  WIDTH  operand A; the mux select per bit.
- in_b  input  WIDTH  operand B; a mux data input.
- in_acc  input  1  start an accumulate sequence; sampled in IDLE only.
- in_last  input  1  final beat of an accumulate sequence.
- out_valid  output  1  result held in output register.
- out_ready  input  1  consumer accepts result.
- out_y  output  WIDTH  result.
- out_beats  output  CNT_W  beats folded into out_y, saturating at all-ones.

Behaviour:
- Per-bit function f(a,b), mux form out = a ? d1 : d0, with (d0,d1):
  - NOT (1,0); AND (0,b); OR (b,1); NAND (1,~b); NOR (~b,0); XOR (b,~b); XNOR (~b,b); PASS (0,1).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat transfers when in_valid && in_ready.
  - The result transfers when out_valid && out_ready.
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_y=0, out_beats=0, acc=0, cnt=0, state=IDLE.
  - Reset overrides any beat transfer in the same cycle, including mid-sequence; a partial accumulation is discarded.
- FSM states: IDLE, ACCUM.
  - IDLE, beat with in_acc=0: out_y<=f(a,b), out_beats<=1, out_valid<=1. Stays IDLE. in_last is ignored.
  - IDLE, beat with in_acc=1, in_last=0: acc<=f(a,b), cnt<=1, go to ACCUM. No output.
  - IDLE, beat with in_acc=1, in_last=1: behaves as a single beat (out_beats=1).
  - ACCUM, any beat: the effective A operand is acc; in_a is ignored; in_acc is ignored. Each beat uses its own in_op.
  - ACCUM, in_last=0: acc<=f(acc,b), cnt<=sat(cnt+1). No output.
  - ACCUM, in_last=1: out_y<=f(acc,b), out_beats<=sat(cnt+1), out_valid<=1, return to IDLE.
- Latency: the result appears 1 cycle after the producing beat transfers.
- Absorbed (non-last ACCUM) beats still require in_ready=1.
- Output register:
  - Holds value while out_valid && !out_ready.
  - out_valid clears on an out transfer unless a producing beat transfers in the same cycle. In that case it reloads with the new value; full throughput is 1 beat/cycle.
- Saturation: cnt and out_beats stop at 2^CNT_W-1 and never wrap.
- Stall rules: out_y, out_beats, acc, cnt and state are stable while no transfer occurs. Source-side in_* values are don't-care when in_valid=0.

Test Plan:
- WIDTH=8, single beats with a=8'hF0, b=8'hCC, ops 0..7 back-to-back, out_ready=1 -> out_y sequence 0F, C0, FC, 3F, 03, 3C, C3, F0; out_beats=1 each; one result per cycle, 1-cycle latency.
- Accumulate: beat1 op=XOR a=8'h0F b=8'h01 acc=1; beat2 op=AND b=8'h07; beat3 op=OR b=8'h80 last=1.
  - Expect no output for beats 1-2.
  - Then out_y=8'h86, out_beats=3, state back to IDLE.
- Backpressure: hold out_ready=0 for 3 cycles after a result.
  - out_y held stable; in_ready=0; the next beat is not consumed.
  - Raise out_ready with in_valid=1: drain and reload occur in the same cycle.
- Saturation: CNT_W=2, 5-beat accumulate of op=PASS -> out_beats=3, out_y equals the first beat's a.
- Reset mid-sequence: assert rst after 2 accumulate beats.
  - Outputs zero, state IDLE.
  - A following single beat (AND a=8'hFF b=8'h5A) yields out_y=8'h5A, out_beats=1.
- Reset with out_valid=1 and in_valid=1 simultaneously -> after the edge out_valid=0, nothing captured.
